// File: rtl/primitive_arbiter.sv
// primitive_arbiter
//
// Round-robin arbiter sharing one field-arithmetic primitive among three
// sequencers (point-operation, Frobenius/tau, inversion). A requester owns the
// datapath for a whole session. A primitive operation still in flight when the
// owner releases is carried to completion in DRAIN.
//
// Ports:
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   req_i[2:0]         per-requester session request, held for the session
//   cg0_i..cg2_i       requester control groups, bit 0 = en_primitive
//   done_primitive_i   one-cycle completion pulse from the primitive
//   control_group_o    control group presented to the datapath
//   grant_o[2:0]       registered one-hot grant, 0 when nobody owns
//   done_out_o[2:0]    done_primitive_i forwarded to the current owner only
//   busy_o             high while in OWN or DRAIN
//   op_count_o         saturating count of completions seen in OWN/DRAIN
module primitive_arbiter #(
    parameter int unsigned CG_W  = 9,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       req_i,
    input  logic [CG_W-1:0]  cg0_i,
    input  logic [CG_W-1:0]  cg1_i,
    input  logic [CG_W-1:0]  cg2_i,
    input  logic             done_primitive_i,
    output logic [CG_W-1:0]  control_group_o,
    output logic [2:0]       grant_o,
    output logic [2:0]       done_out_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       last_q, last_d;
    logic             op_active_q, op_active_d;
    logic [CG_W-1:0]  cg_hold_q, cg_hold_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [CG_W-1:0]  owner_cg;
    logic             owner_req;
    logic [1:0]       sel_idx;
    logic [CG_W-1:0]  cg_mux;
    logic [2:0]       done_mux;

    // Owner's control group and request, selected by the registered grant.
    always_comb begin
        owner_cg  = '0;
        owner_req = 1'b0;
        unique case (grant_q)
            3'b001: begin owner_cg = cg0_i; owner_req = req_i[0]; end
            3'b010: begin owner_cg = cg1_i; owner_req = req_i[1]; end
            3'b100: begin owner_cg = cg2_i; owner_req = req_i[2]; end
            default: begin owner_cg = '0; owner_req = 1'b0; end
        endcase
    end

    // First set request scanning cyclically from last_q + 1.
    always_comb begin
        sel_idx = 2'd0;
        unique case (last_q)
            2'd0: begin
                if (req_i[1])      sel_idx = 2'd1;
                else if (req_i[2]) sel_idx = 2'd2;
                else               sel_idx = 2'd0;
            end
            2'd1: begin
                if (req_i[2])      sel_idx = 2'd2;
                else if (req_i[0]) sel_idx = 2'd0;
                else               sel_idx = 2'd1;
            end
            default: begin
                if (req_i[0])      sel_idx = 2'd0;
                else if (req_i[1]) sel_idx = 2'd1;
                else               sel_idx = 2'd2;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cg_hold_d = cg_hold_q;
        cg_mux    = '0;
        done_mux  = '0;

        unique case (state_q)
            StIdle: begin
                if (req_i != 3'b000) begin
                    grant_d = 3'b001 << sel_idx;
                    last_d  = sel_idx;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                cg_mux   = owner_cg;
                done_mux = grant_q & {3{done_primitive_i}};
                if (owner_req) begin
                    // Freezes once the owner lets go, so DRAIN replays the
                    // last control group issued under an active request.
                    cg_hold_d = owner_cg;
                end else if (!op_active_q || done_primitive_i) begin
                    state_d = StIdle;
                    grant_d = '0;
                end else begin
                    state_d = StDrain;
                    grant_d = '0;
                end
            end
            StDrain: begin
                // Keep en_primitive asserted so the in-flight op finishes.
                cg_mux = cg_hold_q | {{(CG_W-1){1'b0}}, 1'b1};
                if (done_primitive_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        op_active_d = ~done_primitive_i &
                      (op_active_q | ((state_q == StOwn) & cg_mux[0]));

        op_count_d = op_count_q;
        if (done_primitive_i && (state_q != StIdle) && (op_count_q != {CNT_W{1'b1}})) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= 2'd2;
            op_active_q <= 1'b0;
            cg_hold_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            op_active_q <= op_active_d;
            cg_hold_q   <= cg_hold_d;
            op_count_q  <= op_count_d;
        end
    end

    // Reset blanks the datapath-facing outputs immediately, not just after the edge.
    assign control_group_o = rst_i ? '0 : cg_mux;
    assign done_out_o      = rst_i ? 3'b000 : done_mux;
    assign busy_o          = ~rst_i & (state_q != StIdle);
    assign grant_o         = grant_q;
    assign op_count_o      = op_count_q;

endmodule
